picture_window_walker: RTL

Parametrised successor of the picture pointer array. It generates convolution-window read addresses for N_UNITS parallel output pixels, covering full 2-D output traversal, stride, dilation and optional zero padding. A valid/ready stream feeds the feature-map memory read port, and a start/busy/done control interface is driven by the layer sequencer.

---
 rtl/picture_window_walker_if.sv | 33 +++
 rtl/picture_window_walker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/picture_window_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : picture_window_walker_if
// Description : Beat stream from the window walker to the feature-map read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface picture_window_walker_if #(
    parameter int N_UNITS = 4,
    parameter int ADDR_W  = 32
);
    logic                            out_valid;
    logic                            out_ready;
    logic [N_UNITS-1:0][ADDR_W-1:0]  addr_out;
    logic [N_UNITS-1:0]              lane_valid;
    logic [N_UNITS-1:0]              pad_mask;

    modport master (
        output out_valid,
        output addr_out,
        output lane_valid,
        output pad_mask,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  addr_out,
        input  lane_valid,
        input  pad_mask,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/picture_window_walker.sv
`default_nettype none
// ============================================================================
// Module      : picture_window_walker
// Description : Convolution-window address walker for N_UNITS parallel output
//               columns with stride, dilation and (PAD_MASK_EN) zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module picture_window_walker #(
    parameter int N_UNITS = 4,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16,
    parameter int K_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        cfg_base_i,
    input  logic [DIM_W-1:0]         cfg_width_i,
    input  logic [DIM_W-1:0]         cfg_height_i,
    input  logic [K_W-1:0]           cfg_kernel_i,
    input  logic [K_W-1:0]           cfg_dilation_i,
    input  logic [K_W-1:0]           cfg_stride_i,
    input  logic [K_W-1:0]           cfg_pad_i,
    input  logic [N_UNITS-1:0]       active_units_i,
    output logic                     busy_o,
    output logic                     done_o,
    picture_window_walker_if.master  bus
);
    localparam int OW = DIM_W + 1;
    localparam int SW = DIM_W + 2;
    localparam int CW = DIM_W + 2*K_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A position is in range when its whole (dilated) window fits the padded extent.
    function automatic logic fits(input logic [OW-1:0] pos, input logic [K_W-1:0] stride,
                                  input logic [2*K_W-1:0] span, input logic [CW-1:0] limit);
        return (CW'(pos) * CW'(stride) + CW'(span)) < limit;
    endfunction

    state_t                 state_q, state_d;
    logic [OW-1:0]          oy_q, oy_d, oxg_q, oxg_d;
    logic [K_W-1:0]         ky_q, ky_d, kx_q, kx_d;
    logic [ADDR_W-1:0]      base_q;
    logic [DIM_W-1:0]       width_q;
    logic [K_W-1:0]         k_q, dil_q, stride_q, pad_q;
    logic [N_UNITS-1:0]     active_q;
    logic [2*K_W-1:0]       span_q;
    logic [CW-1:0]          ext_w_q, ext_h_q;

    logic [K_W-1:0]         w_dil, w_stride, w_pad;
    logic [2*K_W-1:0]       w_span;
    logic [CW-1:0]          w_ext_w, w_ext_h;
    logic                   w_empty, w_run, w_accept;
    logic signed [SW-1:0]   w_iy;
    logic [ADDR_W-1:0]      w_row;
    logic [N_UNITS-1:0]     w_lv_vec, w_pm_vec;
    logic [N_UNITS-1:0][ADDR_W-1:0] w_addr_vec;

`ifdef PAD_MASK_EN
    logic [DIM_W-1:0]       height_q;
    assign w_pad = cfg_pad_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            height_q <= '0;
        end else if (state_q == S_LOAD) begin
            height_q <= cfg_height_i;
        end
    end
`else
    logic                   w_unused_pad;
    assign w_pad        = '0;
    assign w_unused_pad = ^cfg_pad_i;
`endif

    always_comb begin
        w_dil    = (cfg_dilation_i == '0) ? K_W'(1) : cfg_dilation_i;
        w_stride = (cfg_stride_i == '0) ? K_W'(1) : cfg_stride_i;
        w_span   = (2*K_W)'(w_dil) * (2*K_W)'(cfg_kernel_i - K_W'(1));
        w_ext_w  = CW'(cfg_width_i) + CW'(w_pad) + CW'(w_pad);
        w_ext_h  = CW'(cfg_height_i) + CW'(w_pad) + CW'(w_pad);
        w_empty  = (cfg_kernel_i == '0) || (CW'(w_span) >= w_ext_w) || (CW'(w_span) >= w_ext_h);
    end

    assign w_run    = (state_q == S_RUN);
    assign w_accept = w_run && bus.out_ready;

    always_comb begin
        state_d = state_q;
        oy_d    = oy_q;
        oxg_d   = oxg_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: begin
                oy_d    = '0;
                oxg_d   = '0;
                ky_d    = '0;
                kx_d    = '0;
                state_d = w_empty ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_accept) begin
                    if (kx_q != k_q - K_W'(1)) begin
                        kx_d = kx_q + K_W'(1);
                    end else begin
                        kx_d = '0;
                        if (ky_q != k_q - K_W'(1)) begin
                            ky_d = ky_q + K_W'(1);
                        end else begin
                            ky_d = '0;
                            if (fits(oxg_q + OW'(N_UNITS), stride_q, span_q, ext_w_q)) begin
                                oxg_d = oxg_q + OW'(N_UNITS);
                            end else begin
                                oxg_d = '0;
                                if (fits(oy_q + OW'(1), stride_q, span_q, ext_h_q)) begin
                                    oy_d = oy_q + OW'(1);
                                end else begin
                                    state_d = S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            oy_q     <= '0;
            oxg_q    <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            base_q   <= '0;
            width_q  <= '0;
            k_q      <= '0;
            dil_q    <= '0;
            stride_q <= '0;
            pad_q    <= '0;
            active_q <= '0;
            span_q   <= '0;
            ext_w_q  <= '0;
            ext_h_q  <= '0;
        end else begin
            state_q <= state_d;
            oy_q    <= oy_d;
            oxg_q   <= oxg_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            if (state_q == S_LOAD) begin
                base_q   <= cfg_base_i;
                width_q  <= cfg_width_i;
                k_q      <= cfg_kernel_i;
                dil_q    <= w_dil;
                stride_q <= w_stride;
                pad_q    <= w_pad;
                active_q <= active_units_i;
                span_q   <= w_span;
                ext_w_q  <= w_ext_w;
                ext_h_q  <= w_ext_h;
            end
        end
    end

    // Coordinates only need to be exact modulo 2^SW; valid taps always fit.
    assign w_iy  = SW'(oy_q) * SW'(stride_q) - SW'(pad_q) + SW'(ky_q) * SW'(dil_q);
    assign w_row = base_q + {{(ADDR_W-SW){w_iy[SW-1]}}, w_iy} * ADDR_W'(width_q);

    for (genvar u = 0; u < N_UNITS; u++) begin : g_lane
        logic [OW-1:0]         w_ox;
        logic signed [SW-1:0]  w_ix;

        assign w_ox        = oxg_q + OW'(u);
        assign w_ix        = SW'(w_ox) * SW'(stride_q) - SW'(pad_q) + SW'(kx_q) * SW'(dil_q);
        assign w_lv_vec[u] = w_run && active_q[u] && fits(w_ox, stride_q, span_q, ext_w_q);
`ifdef PAD_MASK_EN
        assign w_pm_vec[u] = w_lv_vec[u] &&
                             ((w_ix < 0) || (w_ix >= $signed({2'b00, width_q})) ||
                              (w_iy < 0) || (w_iy >= $signed({2'b00, height_q})));
`else
        assign w_pm_vec[u] = 1'b0;
`endif
        assign w_addr_vec[u] = (w_lv_vec[u] && !w_pm_vec[u]) ?
                               w_row + {{(ADDR_W-SW){w_ix[SW-1]}}, w_ix} : '0;
    end

    assign bus.out_valid  = w_run;
    assign bus.lane_valid = w_lv_vec;
    assign bus.pad_mask   = w_pm_vec;
    assign bus.addr_out   = w_addr_vec;
    assign busy_o         = (state_q == S_LOAD) || w_run;
    assign done_o         = (state_q == S_DONE);

endmodule
`default_nettype wire
